// File: rtl/rtype_issue_queue.sv
// rtype_issue_queue: FIFO of R-type words feeding the single-cycle core one instruction per clock,
// issuing the all-zero NOP whenever no real word is available.
module rtype_issue_queue #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [31:0]                in_instr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       start,
   input  logic                       drain,
   output logic [31:0]                instruction,
   output logic                       issue_valid,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_W-1:0]           issued_cnt,
   output logic [CNT_W-1:0]           bubble_cnt,
   output logic [CNT_W-1:0]           reject_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;
   logic [31:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic fire, store, reject, active, pop, bubble, finish;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == IDLE ? (start ? RUN : IDLE) :
                 state == RUN  ? (drain ? DRAIN : RUN) :
                 (level == '0 ? IDLE : DRAIN);
   always_comb begin
      in_ready = level < LW'(DEPTH) && state != DRAIN;
      fire     = in_valid && in_ready;
      store    = fire && in_instr[31:26] == 6'd0;
      reject   = fire && in_instr[31:26] != 6'd0;
      active   = state != IDLE;
      pop      = active && level != '0;
      bubble   = active && level == '0;
      finish   = state == DRAIN && level == '0;
      busy     = active;
   end
   // Storage is not reset: contents are meaningless until written, and the level gates every read.
   always_ff @(posedge clk)
      if (store) mem[wr_ptr] <= in_instr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         instruction <= '0;
         issue_valid <= 1'b0;
         done        <= 1'b0;
         issued_cnt  <= '0;
         bubble_cnt  <= '0;
         reject_cnt  <= '0;
      end else begin
         rd_ptr      <= rd_ptr + AW'(pop);
         wr_ptr      <= wr_ptr + AW'(store);
         level       <= level + LW'(store) - LW'(pop);
         instruction <= pop ? mem[rd_ptr] : 32'h0000_0000;
         issue_valid <= pop;
         done        <= finish;
         issued_cnt  <= issued_cnt + CNT_W'(pop && !(&issued_cnt));
         bubble_cnt  <= bubble_cnt + CNT_W'(bubble && !(&bubble_cnt));
         reject_cnt  <= reject_cnt + CNT_W'(reject && !(&reject_cnt));
      end
endmodule
